// File: rtl/flash_boot_loader_if.sv
// Flash read port between the boot loader and the flash controller.
// Loader issues req/c_addr; flash answers with ack, then valid/data.
interface flash_boot_loader_if;
  logic        req;
  logic [19:0] c_addr;
  logic        ack;
  logic        valid;
  logic [31:0] data;

  modport master (
    output req, c_addr,
    input  ack, valid, data
  );

  modport slave (
    input  req, c_addr,
    output ack, valid, data
  );
endinterface

// File: rtl/flash_boot_loader.sv
// Copies len_words 32-bit words from flash into RAM, one request at a time.
// A per-word watchdog aborts the copy and raises a sticky err.
module flash_boot_loader #(
  parameter int TIMEOUT = 4096,
  parameter int RAM_AW  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [19:0]       src_addr_i,
  input  logic [15:0]       len_words_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  flash_boot_loader_if.master flash,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [19:0]       cur_addr_q, cur_addr_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [RAM_AW-1:0] idx_q, idx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic [19:0]       c_addr_q, c_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
      c_addr_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      done_q      <= done_d;
      req_q       <= req_d;
      c_addr_q    <= c_addr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next state; valid is taken in REQ as well as WAIT, ahead of timeout.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    done_d      = 1'b0;
    c_addr_d    = c_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cur_addr_d  = src_addr_i;
          remaining_d = len_words_i;
          idx_d       = '0;
          err_d       = 1'b0;
          if (len_words_i == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d  = REQ;
            c_addr_d = src_addr_i;
            tmo_d    = '0;
          end
        end
      end
      REQ, WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (flash.valid) begin
          state_d     = WRITE;
          ram_wdata_d = flash.data;
          ram_addr_d  = idx_q;
        end else if (tmo_q == TMAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (state_q == REQ && flash.ack) begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        cur_addr_d  = cur_addr_q + 20'd4;
        idx_d       = idx_q + 1'b1;
        remaining_d = remaining_q - 16'd1;
        if (remaining_q == 16'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d  = REQ;
          c_addr_d = cur_addr_q + 20'd4;
          tmo_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d    = (state_d == REQ);
    ram_we_d = (state_d == WRITE);
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign flash.req    = req_q;
  assign flash.c_addr = c_addr_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;

endmodule
